// File: rtl/puf_pkg.sv
// Shared definitions for the PUF measurement and voting blocks.
// Holds the primitive-ID width default, the width helper, and the voter FSM encodings.
package puf_pkg;

  // Primitive ID width shared with the measurement stage.
  localparam int unsigned C_OIDWIDTH_DEF = 24;

  // Bits needed to hold values 0..n-1. Never returns less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((33'd1 << w) < 33'(n))) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Voter session states.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_EVAL = 3'd3,
    S_DONE = 3'd4
  } vote_state_e;

endpackage

// File: rtl/meas_vote_cnt.sv
// Per-bit accumulator: counts how many repetitions returned a 1 for one ID bit.
// Ports:
//   clk_i, rst_n_i  clock and async active-low reset
//   clr_i           zero the count (takes priority over inc_i)
//   inc_i           add bit_i to the count
//   bit_i           this repetition's value for the bit
//   maj_c_o         count is above half the repetitions (combinational from count)
//   unst_c_o        bit was neither always 0 nor always 1 (combinational from count)
module meas_vote_cnt
  import puf_pkg::*;
#(
  parameter int unsigned C_REPNUM = 5
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic inc_i,
  input  logic bit_i,
  output logic maj_c_o,
  output logic unst_c_o
);

  localparam int unsigned CW = clog2(C_REPNUM + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count update; bounded by C_REPNUM because the FSM increments at most that often.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(bit_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign maj_c_o  = (cnt_q > CW'(C_REPNUM / 2));
  assign unst_c_o = (cnt_q != '0) && (cnt_q != CW'(C_REPNUM));

endmodule

// File: rtl/meas_vote.sv
// Repeats the PUF measurement C_REPNUM times per session, majority-votes each ID bit
// and reports which bits disagreed. A stalled measurement stage ends the session with O_err.
// Ports:
//   I_sclk, I_rst_n      clock, async active-low reset
//   I_start              session start (IDLE only)
//   O_meas_start         one-cycle request for one ID reading
//   I_prim_id/I_prim_vld reading from the measurement stage
//   O_id, O_mask, O_err  voted ID, instability mask, timeout flag
//   O_vld/I_rdy          result handshake, O_vld held until accepted
//   O_busy               session in progress
module meas_vote
  import puf_pkg::*;
#(
  parameter int unsigned C_OIDWIDTH = C_OIDWIDTH_DEF,
  parameter int unsigned C_REPNUM   = 5,
  parameter int unsigned C_TIMEOUT  = 4096
) (
  input  logic                  I_sclk,
  input  logic                  I_rst_n,
  input  logic                  I_start,
  output logic                  O_meas_start,
  input  logic [C_OIDWIDTH-1:0] I_prim_id,
  input  logic                  I_prim_vld,
  output logic [C_OIDWIDTH-1:0] O_id,
  output logic [C_OIDWIDTH-1:0] O_mask,
  output logic                  O_err,
  output logic                  O_vld,
  input  logic                  I_rdy,
  output logic                  O_busy
);

  localparam int unsigned RW = clog2(C_REPNUM + 1);
  localparam int unsigned TW = clog2(C_TIMEOUT);

  // An even count has no strict majority; fewer than three cannot flag instability meaningfully.
  if (((C_REPNUM % 2) == 0) || (C_REPNUM < 3)) begin : g_bad_repnum
    $error("meas_vote: C_REPNUM must be odd and at least 3");
  end

  vote_state_e            state_q, state_d;
  logic [RW-1:0]          rep_q, rep_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [C_OIDWIDTH-1:0]  id_q, id_d;
  logic [C_OIDWIDTH-1:0]  mask_q, mask_d;
  logic                   err_q, err_d;
  logic                   meas_start_q, vld_q, busy_q;
  logic                   clr_c, inc_c;
  logic [C_OIDWIDTH-1:0]  maj_c, unst_c;

  // One accumulator per ID bit.
  for (genvar b = 0; b < int'(C_OIDWIDTH); b++) begin : g_bit
    meas_vote_cnt #(
      .C_REPNUM(C_REPNUM)
    ) u_cnt (
      .clk_i   (I_sclk),
      .rst_n_i (I_rst_n),
      .clr_i   (clr_c),
      .inc_i   (inc_c),
      .bit_i   (I_prim_id[b]),
      .maj_c_o (maj_c[b]),
      .unst_c_o(unst_c[b])
    );
  end

  // Session sequencing and result capture.
  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    tmo_d   = tmo_q;
    id_d    = id_q;
    mask_d  = mask_q;
    err_d   = err_q;
    clr_c   = 1'b0;
    inc_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (I_start) begin
          state_d = S_REQ;
          clr_c   = 1'b1;
          rep_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_REQ: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A reading arriving on the last allowed cycle still counts.
        if (I_prim_vld) begin
          inc_c = 1'b1;
          rep_d = rep_q + RW'(1);
          if (rep_q == RW'(C_REPNUM - 1)) begin
            state_d = S_EVAL;
          end else begin
            state_d = S_REQ;
          end
        end else if (tmo_q == TW'(C_TIMEOUT - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          id_d    = '0;
          mask_d  = '1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_EVAL: begin
        id_d    = maj_c;
        mask_d  = unst_c;
        err_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (I_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; strobes are decoded from the next state so they align with it.
  always_ff @(posedge I_sclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q      <= S_IDLE;
      rep_q        <= '0;
      tmo_q        <= '0;
      id_q         <= '0;
      mask_q       <= '0;
      err_q        <= 1'b0;
      meas_start_q <= 1'b0;
      vld_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rep_q        <= rep_d;
      tmo_q        <= tmo_d;
      id_q         <= id_d;
      mask_q       <= mask_d;
      err_q        <= err_d;
      meas_start_q <= (state_d == S_REQ);
      vld_q        <= (state_d == S_DONE);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign O_meas_start = meas_start_q;
  assign O_id         = id_q;
  assign O_mask       = mask_q;
  assign O_err        = err_q;
  assign O_vld        = vld_q;
  assign O_busy       = busy_q;

endmodule

// File: tb/tb_meas_vote.sv
// Randomized bench for meas_vote: a driver plays host and measurement stage and pushes
// the expected result of each session; a monitor pops and checks whenever O_vld is shown.
module tb_meas_vote;

  localparam int unsigned W = 8;
  localparam int unsigned R = 5;
  localparam int unsigned T = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         pvld = 1'b0;
  logic         rdy = 1'b0;
  logic [W-1:0] pid = '0;
  logic         ms, ovld, oerr, obusy;
  logic [W-1:0] oid, omask;

  meas_vote #(
    .C_OIDWIDTH(W),
    .C_REPNUM  (R),
    .C_TIMEOUT (T)
  ) dut (
    .I_sclk      (clk),
    .I_rst_n     (rst_n),
    .I_start     (start),
    .O_meas_start(ms),
    .I_prim_id   (pid),
    .I_prim_vld  (pvld),
    .O_id        (oid),
    .O_mask      (omask),
    .O_err       (oerr),
    .O_vld       (ovld),
    .I_rdy       (rdy),
    .O_busy      (obusy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct packed {
    logic [W-1:0] id;
    logic [W-1:0] mask;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic have_cur = 1'b0;
  logic prev_vld = 1'b0;
  int   n_ms = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk = n_chk + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: bitwise majority by counting ones; unstable where bits are not all equal.
  task automatic model(input logic [W-1:0] rd[R], output logic [W-1:0] id,
                       output logic [W-1:0] mask);
    logic [W-1:0] any1, all1;
    any1 = '0;
    all1 = '1;
    for (int r = 0; r < int'(R); r++) begin
      any1 = any1 | rd[r];
      all1 = all1 & rd[r];
    end
    for (int b = 0; b < int'(W); b++) begin
      int ones;
      ones = 0;
      for (int r = 0; r < int'(R); r++) ones = ones + int'(rd[r][b]);
      id[b] = (2 * ones > int'(R));
    end
    mask = any1 & ~all1;
  endtask

  // Monitor: pop on each new result, then hold the result to the expectation while shown.
  always @(negedge clk) begin
    if (ms) n_ms = n_ms + 1;
    if (ovld && !prev_vld) begin
      if (q.size() == 0) begin
        chk("vld_without_expectation", 32'(q.size()), 32'd1);
        have_cur = 1'b0;
      end else begin
        cur = q.pop_front();
        have_cur = 1'b1;
        chk("vld_cycle", 32'(cyc), 32'(cur.cyc));
      end
    end
    if (ovld && have_cur) begin
      chk("o_id", 32'(oid), 32'(cur.id));
      chk("o_mask", 32'(omask), 32'(cur.mask));
      chk("o_err", 32'(oerr), 32'(cur.err));
    end
    prev_vld = ovld;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ms(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (ms) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_meas_start"}, 32'(ms), 32'd0);
    chk({tag, "_vld"}, 32'(ovld), 32'd0);
    chk({tag, "_err"}, 32'(oerr), 32'd0);
    chk({tag, "_busy"}, 32'(obusy), 32'd0);
    chk({tag, "_id"}, 32'(oid), 32'd0);
    chk({tag, "_mask"}, 32'(omask), 32'd0);
  endtask

  // One session. stall_at/abort_at < 0 disable those; fixed_w > 0 sets the WAIT cycle of the last reading.
  task automatic session(input logic [W-1:0] rd[R], input int stall_at, input int abort_at,
                         input int fixed_w, input bit noise, input int hold,
                         input bit start_in_done);
    logic [W-1:0] eid, emask;
    exp_t x;
    bit   ok;
    int   ms0, e, w, pulses;
    model(rd, eid, emask);
    if (noise) begin
      pid = '1;
      pvld = 1'b1;
      tick();
      pvld = 1'b0;
    end
    ms0 = n_ms;
    pulses = int'(R);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < int'(R); r++) begin
      if (r == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_zero_outputs("abort");
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      wait_ms(ok);
      chk("meas_start_seen", 32'(ok), 32'd1);
      if (!ok) return;
      e = cyc;
      if (noise) begin
        pid = '1;
        pvld = 1'b1;
      end
      tick();
      pvld = 1'b0;
      if (r == stall_at) begin
        x = '{id: '0, mask: '1, err: 1'b1, cyc: e + 1 + int'(T)};
        q.push_back(x);
        pulses = r + 1;
        break;
      end
      w = (fixed_w > 0 && r == int'(R) - 1) ? fixed_w : int'($urandom_range(1, 4));
      repeat (w - 1) tick();
      pid = rd[r];
      pvld = 1'b1;
      tick();
      pvld = 1'b0;
      pid = W'($urandom);
      if (r == int'(R) - 1) begin
        x = '{id: eid, mask: emask, err: 1'b0, cyc: cyc + 1};
        q.push_back(x);
      end
    end
    for (int i = 0; i < 64; i++) begin
      if (ovld) break;
      tick();
    end
    chk("vld_seen", 32'(ovld), 32'd1);
    chk("busy_in_done", 32'(obusy), 32'd1);
    for (int i = 0; i < hold; i++) begin
      start = (start_in_done && i == 3);
      tick();
    end
    start = 1'b0;
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("vld_after_ack", 32'(ovld), 32'd0);
    chk("busy_after_ack", 32'(obusy), 32'd0);
    chk("meas_start_count", 32'(n_ms - ms0), 32'(pulses));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rd[R];
    repeat (3) tick();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick();

    rd = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    session(rd, -1, -1, 0, 1'b0, 0, 1'b0);
    rd = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00};
    session(rd, -1, -1, 0, 1'b0, 1, 1'b0);
    rd = '{8'h0F, 8'h0F, 8'h0F, 8'hF0, 8'hF0};
    session(rd, -1, -1, 0, 1'b1, 2, 1'b0);
    rd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    session(rd, 1, -1, 0, 1'b0, 2, 1'b0);
    rd = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    session(rd, -1, -1, int'(T), 1'b0, 0, 1'b0);
    rd = '{8'hC3, 8'h81, 8'hC3, 8'h42, 8'hE7};
    session(rd, -1, -1, 0, 1'b0, 10, 1'b1);
    rd = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    session(rd, -1, 3, 0, 1'b0, 0, 1'b0);
    rd = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    session(rd, -1, -1, 0, 1'b0, 0, 1'b0);

    for (int s = 0; s < 20; s++) begin
      for (int r = 0; r < int'(R); r++) rd[r] = W'($urandom);
      session(rd, -1, -1, 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
    end

    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
